// File: rtl/maze_pkg.sv
// Shared maze types: direction encoding used by solver and replay,
// replay FSM states and the default coordinate width.
package maze_pkg;

  localparam int COORD_W = 4;

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_DOWN  = 2'b11
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EMIT  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_FETCH = 3'd3,
    ST_DONE  = 3'd4
  } replay_state_t;

  // UP and DOWN move along Y; the others along X.
  function automatic logic dir_is_vertical(input dir_t d);
    return (d == DIR_UP) || (d == DIR_DOWN);
  endfunction

  // UP and RIGHT increase the coordinate; LEFT and DOWN decrease it.
  function automatic logic dir_is_plus(input dir_t d);
    return (d == DIR_UP) || (d == DIR_RIGHT);
  endfunction

endpackage

// File: rtl/step_delay_timer.sv
// Loadable down-counter; expire flags the final counted cycle (count == 1).
module step_delay_timer #(
  parameter int DELAY_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic [DELAY_W-1:0] load_val,
  input  logic               en,
  output logic               expire
);

  logic [DELAY_W-1:0] cnt_q, cnt_d;

  // Load takes priority over counting; the counter never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != {DELAY_W{1'b0}})) begin
      cnt_d = cnt_q - {{(DELAY_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= {DELAY_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = (cnt_q == {{(DELAY_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/path_replay_ctrl.sv
// Replays a solved path: drains the direction deque and emits each visited
// cell from the fixed start over a valid/ready handshake with step delay.
module path_replay_ctrl
  import maze_pkg::*;
#(
  parameter int N       = COORD_W,
  parameter int DELAY_W = 16,
  parameter int START_X = 0,
  parameter int START_Y = 0
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic [DELAY_W-1:0] step_delay,
  input  logic               deque_empty,
  input  logic [1:0]         deque_front,
  output logic               pop_front,
  output logic [N-1:0]       pos_x,
  output logic [N-1:0]       pos_y,
  output logic               pos_valid,
  input  logic               pos_ready,
  output logic               busy,
  output logic               done,
  output logic               err
);

  replay_state_t      state_q, state_d;
  logic [N-1:0]       pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [DELAY_W-1:0] dly_q, dly_d;
  logic               err_q, err_d;
  logic               pop_s, tmr_load_s, tmr_en_s, tmr_expire_s;
  dir_t               dir_s;
  logic               vert_s, plus_s, at_edge_s;
  logic [N-1:0]       cur_s, nxt_s;

  step_delay_timer #(.DELAY_W(DELAY_W)) u_timer (
    .clk      (Clk),
    .rst_n    (Rst_n),
    .load     (tmr_load_s),
    .load_val (dly_q),
    .en       (tmr_en_s),
    .expire   (tmr_expire_s)
  );

  // Move decode: pick the affected axis and detect a move off the grid edge.
  always_comb begin
    dir_s     = dir_t'(deque_front);
    vert_s    = dir_is_vertical(dir_s);
    plus_s    = dir_is_plus(dir_s);
    cur_s     = vert_s ? pos_y_q : pos_x_q;
    at_edge_s = plus_s ? (cur_s == {N{1'b1}}) : (cur_s == {N{1'b0}});
    nxt_s     = plus_s ? (cur_s + {{(N-1){1'b0}}, 1'b1})
                       : (cur_s - {{(N-1){1'b0}}, 1'b1});
  end

  // Next-state logic; abort overrides start and the handshake.
  always_comb begin
    state_d    = state_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    dly_d      = dly_q;
    err_d      = err_q;
    pop_s      = 1'b0;
    tmr_load_s = 1'b0;
    tmr_en_s   = 1'b0;
    if (abort && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            pos_x_d = N'(START_X);
            pos_y_d = N'(START_Y);
            dly_d   = step_delay;
            err_d   = 1'b0;
            state_d = ST_EMIT;
          end else begin
            state_d = state_q;
          end
        end
        ST_EMIT: begin
          if (!pos_ready) begin
            state_d = ST_EMIT;
          end else if (deque_empty) begin
            state_d = ST_DONE;
          end else if (dly_q == {DELAY_W{1'b0}}) begin
            state_d = ST_FETCH;
          end else begin
            tmr_load_s = 1'b1;
            state_d    = ST_WAIT;
          end
        end
        ST_WAIT: begin
          tmr_en_s = 1'b1;
          state_d  = tmr_expire_s ? ST_FETCH : ST_WAIT;
        end
        ST_FETCH: begin
          if (deque_empty) begin
            state_d = ST_DONE;
          end else if (at_edge_s) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            pop_s = 1'b1;
            if (vert_s) begin
              pos_y_d = nxt_s;
            end else begin
              pos_x_d = nxt_s;
            end
            state_d = ST_EMIT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      pos_x_q <= N'(START_X);
      pos_y_q <= N'(START_Y);
      dly_q   <= {DELAY_W{1'b0}};
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      dly_q   <= dly_d;
      err_q   <= err_d;
    end
  end

  assign pop_front = pop_s;
  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign pos_valid = (state_q == ST_EMIT);
  assign busy      = (state_q == ST_EMIT) || (state_q == ST_WAIT) || (state_q == ST_FETCH);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;

endmodule

// File: tb/tb_path_replay_ctrl.sv
// Directed bench for path_replay_ctrl with a small deque model.
module tb_path_replay_ctrl;

  logic        Clk = 1'b0;
  logic        Rst_n, start, abort, deque_empty, pop_front;
  logic [15:0] step_delay;
  logic [1:0]  deque_front;
  logic [3:0]  pos_x, pos_y;
  logic        pos_valid, pos_ready, busy, done, err;

  logic [1:0]  dq[$];
  int          pops = 0;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          ex[$], ey[$], ec[$];

  path_replay_ctrl dut (
    .Clk(Clk), .Rst_n(Rst_n), .start(start), .abort(abort),
    .step_delay(step_delay), .deque_empty(deque_empty),
    .deque_front(deque_front), .pop_front(pop_front),
    .pos_x(pos_x), .pos_y(pos_y), .pos_valid(pos_valid),
    .pos_ready(pos_ready), .busy(busy), .done(done), .err(err)
  );

  always #5 Clk = ~Clk;

  always_comb begin
    deque_empty = (dq.size() == 0);
    deque_front = (dq.size() == 0) ? 2'b00 : dq[0];
  end

  always @(posedge Clk) begin
    if (pop_front && dq.size() > 0) begin
      void'(dq.pop_front());
      pops++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic do_start(input logic [15:0] d);
    start      = 1'b1;
    step_delay = d;
    tick();
    start = 1'b0;
  endtask

  task automatic collect();
    ex.delete(); ey.delete(); ec.delete();
    for (int i = 0; i < 300; i++) begin
      if (done) break;
      if (pos_valid && pos_ready) begin
        ex.push_back(int'(pos_x));
        ey.push_back(int'(pos_y));
        ec.push_back(cyc);
      end
      tick();
    end
    check("collect_done", {31'd0, done}, 32'd1);
  endtask

  task automatic check_seq(input string tag, input int n, input int xs[4], input int ys[4], input int gap);
    check({tag, "_count"}, ex.size(), n);
    for (int i = 0; i < n && i < ex.size(); i++) begin
      check($sformatf("%s_x%0d", tag, i), ex[i], xs[i]);
      check($sformatf("%s_y%0d", tag, i), ey[i], ys[i]);
      if (i > 0) check($sformatf("%s_gap%0d", tag, i), ec[i] - ec[i-1], gap);
    end
  endtask

  initial begin
    int p0;
    logic stable;
    Rst_n = 1'b0; start = 1'b0; abort = 1'b0; step_delay = 16'd0; pos_ready = 1'b0;
    tick(); tick();
    check("rst_valid", {31'd0, pos_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_pos", {24'd0, pos_x, pos_y}, 32'd0);
    Rst_n = 1'b1;
    tick();

    // 1: empty deque, single emission
    p0 = pops; pos_ready = 1'b1;
    do_start(16'd0);
    check("t1_valid", {31'd0, pos_valid}, 32'd1);
    check("t1_pos", {24'd0, pos_x, pos_y}, 32'd0);
    tick();
    check("t1_done", {31'd0, done}, 32'd1);
    check("t1_valid_off", {31'd0, pos_valid}, 32'd0);
    check("t1_pops", pops - p0, 0);

    // 2: three moves, no delay
    dq = '{2'b00, 2'b01, 2'b01}; p0 = pops;
    do_start(16'd0);
    collect();
    check_seq("t2", 4, '{0, 0, 1, 2}, '{0, 1, 1, 1}, 2);
    check("t2_pops", pops - p0, 3);
    check("t2_err", {31'd0, err}, 32'd0);

    // 3: backpressure holds position
    dq = '{2'b00, 2'b01, 2'b01}; p0 = pops; pos_ready = 1'b0;
    do_start(16'd0);
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!pos_valid || pos_x != 4'd0 || pos_y != 4'd0) stable = 1'b0;
      tick();
    end
    check("t3_stable", {31'd0, stable}, 32'd1);
    check("t3_nopop", pops - p0, 0);
    pos_ready = 1'b1;
    collect();
    check_seq("t3", 4, '{0, 0, 1, 2}, '{0, 1, 1, 1}, 2);
    check("t3_pops", pops - p0, 3);

    // 4: step delay 3, latched at start
    dq = '{2'b01, 2'b01};
    do_start(16'd3);
    step_delay = 16'd0;
    collect();
    check_seq("t4", 3, '{0, 1, 2, 0}, '{0, 0, 0, 0}, 5);

    // 5: illegal LEFT from x=0
    dq = '{2'b10}; p0 = pops;
    do_start(16'd0);
    collect();
    check_seq("t5", 1, '{0, 0, 0, 0}, '{0, 0, 0, 0}, 0);
    check("t5_err", {31'd0, err}, 32'd1);
    check("t5_pops", pops - p0, 0);
    check("t5_pos", {24'd0, pos_x, pos_y}, 32'd0);
    check("t5_dq", dq.size(), 1);
    dq.delete();
    do_start(16'd0);
    check("t5_err_clr", {31'd0, err}, 32'd0);
    check("t5_done_clr", {31'd0, done}, 32'd0);
    collect();

    // 6a: reset during WAIT
    dq = '{2'b01, 2'b01};
    do_start(16'd2);
    tick();
    check("t6_in_wait", {30'd0, busy, pos_valid}, 32'd2);
    Rst_n = 1'b0;
    tick();
    check("t6_rst_outs", {28'd0, pos_valid, busy, done, err}, 32'd0);
    check("t6_rst_pos", {24'd0, pos_x, pos_y}, 32'd0);
    check("t6_rst_pop", {31'd0, pop_front}, 32'd0);
    Rst_n = 1'b1;
    tick();

    // 6b: abort in EMIT, then restart
    dq = '{2'b01}; pos_ready = 1'b0; p0 = pops;
    do_start(16'd0);
    check("t6_emit", {31'd0, pos_valid}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t6_abort_outs", {29'd0, pos_valid, busy, done}, 32'd0);
    check("t6_abort_pops", pops - p0, 0);
    pos_ready = 1'b1;
    do_start(16'd0);
    check("t6_restart", {30'd0, pos_valid, busy}, 32'd3);
    collect();
    check_seq("t6", 2, '{0, 1, 0, 0}, '{0, 0, 0, 0}, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
